// File: rtl/amba3_axi_rd_arbiter.sv
// amba3_axi_rd_arbiter: N-master to 1-slave AMBA3 AXI read-channel arbiter.
// AR is round-robin arbitrated and registered once toward the slave, with the
// grant index prepended to ARID. R beats are routed back combinationally by the
// upper RID bits. Optional macro AMBA3_AXI_RD_ARB_OUTSTANDING_EN caps the number
// of outstanding reads per master at MAX_OUTSTANDING.
// Handshakes: a transfer happens on a rising aclk edge where valid && ready;
// valid never depends on ready, and a registered valid is held with its payload
// stable until the matching ready is seen.
module amba3_axi_rd_arbiter #(
   parameter int NUM_MASTERS     = 2,
   parameter int AXID_SIZE       = 4,
   parameter int ADDR_SIZE       = 32,
   parameter int DATA_SIZE       = 32,
   parameter int MAX_OUTSTANDING = 4,
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int SID_W = AXID_SIZE + IDX_W
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [NUM_MASTERS*AXID_SIZE-1:0] m_arid,
   input  logic [NUM_MASTERS*ADDR_SIZE-1:0] m_araddr,
   input  logic [NUM_MASTERS*4-1:0]       m_arlen,
   input  logic [NUM_MASTERS*3-1:0]       m_arsize,
   input  logic [NUM_MASTERS*2-1:0]       m_arburst,
   input  logic [NUM_MASTERS*2-1:0]       m_arlock,
   input  logic [NUM_MASTERS*4-1:0]       m_arcache,
   input  logic [NUM_MASTERS*3-1:0]       m_arprot,
   input  logic [NUM_MASTERS-1:0]         m_arvalid,
   output logic [NUM_MASTERS-1:0]         m_arready,
   output logic [NUM_MASTERS*AXID_SIZE-1:0] m_rid,
   output logic [NUM_MASTERS*DATA_SIZE-1:0] m_rdata,
   output logic [NUM_MASTERS*2-1:0]       m_rresp,
   output logic [NUM_MASTERS-1:0]         m_rlast,
   output logic [NUM_MASTERS-1:0]         m_rvalid,
   input  logic [NUM_MASTERS-1:0]         m_rready,
   output logic [SID_W-1:0]               s_arid,
   output logic [ADDR_SIZE-1:0]           s_araddr,
   output logic [3:0]                     s_arlen,
   output logic [2:0]                     s_arsize,
   output logic [1:0]                     s_arburst,
   output logic [1:0]                     s_arlock,
   output logic [3:0]                     s_arcache,
   output logic [2:0]                     s_arprot,
   output logic                           s_arvalid,
   input  logic                           s_arready,
   input  logic [SID_W-1:0]               s_rid,
   input  logic [DATA_SIZE-1:0]           s_rdata,
   input  logic [1:0]                     s_rresp,
   input  logic                           s_rlast,
   input  logic                           s_rvalid,
   output logic                           s_rready,
   output logic                           dbg_state
);

   typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       last_grant;
   logic [NUM_MASTERS-1:0] eligible;
   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   logic                   ar_take;
   logic [AXID_SIZE-1:0]   sel_id;
   logic [ADDR_SIZE-1:0]   sel_addr;
   logic [3:0]             sel_len, sel_cache;
   logic [2:0]             sel_size, sel_prot;
   logic [1:0]             sel_burst, sel_lock;
   logic [IDX_W-1:0]       r_idx;

   assign r_idx     = s_rid[SID_W-1:AXID_SIZE];
   assign s_arvalid = (state == ST_ISSUE);
   assign dbg_state = (state == ST_ISSUE);

`ifdef AMBA3_AXI_RD_ARB_OUTSTANDING_EN
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   logic [CNT_W-1:0] out_cnt [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] r_done;

   // A master at its outstanding limit is invisible to the round-robin scan.
   always_comb begin
      eligible = '0;
      r_done   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         eligible[i] = m_arvalid[i] && (out_cnt[i] < CNT_W'(MAX_OUTSTANDING));
         r_done[i]   = s_rvalid && s_rready && s_rlast && (r_idx == IDX_W'(i));
      end
   end

   // Count reads issued minus bursts completed; simultaneous inc/dec cancel.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < NUM_MASTERS; i++) out_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ar_take && (win_idx == IDX_W'(i)) && !r_done[i])
               out_cnt[i] <= out_cnt[i] + 1'b1;
            else if (r_done[i] && !(ar_take && (win_idx == IDX_W'(i))) && (out_cnt[i] != '0))
               out_cnt[i] <= out_cnt[i] - 1'b1;
         end
      end
   end
`else
   // MAX_OUTSTANDING only matters when the outstanding limit is compiled in.
   logic unused_max_outstanding;
   assign unused_max_outstanding = (MAX_OUTSTANDING > 0);
   assign eligible = m_arvalid;
`endif

   // Round-robin pick: lowest eligible index above last_grant, else wrap to lowest overall.
   // Scans run high-to-low so the last assignment is the lowest index; the second
   // scan overrides the wrapped choice whenever an index above last_grant exists.
   always_comb begin
      win_found = |eligible;
      win_idx   = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
         if (eligible[i] && (IDX_W'(i) <= last_grant)) win_idx = IDX_W'(i);
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
         if (eligible[i] && (IDX_W'(i) > last_grant)) win_idx = IDX_W'(i);
   end

   // Select the winner's AR payload.
   always_comb begin
      sel_id = '0; sel_addr = '0; sel_len = '0; sel_size = '0;
      sel_burst = '0; sel_lock = '0; sel_cache = '0; sel_prot = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (win_idx == IDX_W'(i)) begin
            sel_id    = m_arid[i*AXID_SIZE +: AXID_SIZE];
            sel_addr  = m_araddr[i*ADDR_SIZE +: ADDR_SIZE];
            sel_len   = m_arlen[i*4 +: 4];
            sel_size  = m_arsize[i*3 +: 3];
            sel_burst = m_arburst[i*2 +: 2];
            sel_lock  = m_arlock[i*2 +: 2];
            sel_cache = m_arcache[i*4 +: 4];
            sel_prot  = m_arprot[i*3 +: 3];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge aclk) begin
      if (areset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: grant only from IDLE, return to IDLE once the slave accepts.
   always_comb begin
      state_nxt = state;
      ar_take   = 1'b0;
      case (state)
         ST_IDLE:  if (win_found) begin
                      ar_take   = 1'b1;
                      state_nxt = ST_ISSUE;
                   end
         ST_ISSUE: if (s_arready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // One-hot AR ready to the winner while idle; silent during reset.
   always_comb begin
      m_arready = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         m_arready[i] = ar_take && (win_idx == IDX_W'(i)) && !areset;
   end

   // AR register stage toward the slave, plus round-robin pointer.
   always_ff @(posedge aclk) begin
      if (areset) begin
         last_grant <= IDX_W'(NUM_MASTERS - 1);
         s_arid     <= '0;
         s_araddr   <= '0;
         s_arlen    <= '0;
         s_arsize   <= '0;
         s_arburst  <= '0;
         s_arlock   <= '0;
         s_arcache  <= '0;
         s_arprot   <= '0;
      end else if (ar_take) begin
         last_grant <= win_idx;
         s_arid     <= {win_idx, sel_id};
         s_araddr   <= sel_addr;
         s_arlen    <= sel_len;
         s_arsize   <= sel_size;
         s_arburst  <= sel_burst;
         s_arlock   <= sel_lock;
         s_arcache  <= sel_cache;
         s_arprot   <= sel_prot;
      end
   end

   // R routing by RID prefix; an unknown prefix is sunk so the slave never stalls.
   always_comb begin
      m_rvalid = '0;
      s_rready = 1'b1;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            m_rvalid[i] = s_rvalid;
            s_rready    = m_rready[i];
         end
      end
      if (areset) begin
         m_rvalid = '0;
         s_rready = 1'b0;
      end
   end

   assign m_rid   = {NUM_MASTERS{s_rid[AXID_SIZE-1:0]}};
   assign m_rdata = {NUM_MASTERS{s_rdata}};
   assign m_rresp = {NUM_MASTERS{s_rresp}};
   assign m_rlast = {NUM_MASTERS{s_rlast}};

endmodule

// File: tb/tb_amba3_axi_rd_arbiter.sv
// Testbench for amba3_axi_rd_arbiter: a 2-master instance for AR and R checks,
// and a 3-master instance for the out-of-range RID prefix behaviour.
module tb_amba3_axi_rd_arbiter;
   localparam int N = 2, IW = 4, AW = 32, DW = 32, XW = 1, SW = IW + XW;
   localparam int N3 = 3, SW3 = IW + 2;

   logic aclk = 1'b0;
   logic areset = 1'b1;

   logic [N*IW-1:0] m_arid = '0;
   logic [N*AW-1:0] m_araddr = '0;
   logic [N*4-1:0]  m_arlen = '0, m_arcache = '0;
   logic [N*3-1:0]  m_arsize = '0, m_arprot = '0;
   logic [N*2-1:0]  m_arburst = '0, m_arlock = '0;
   logic [N-1:0]    m_arvalid = '0, m_rready = '0;
   logic [N-1:0]    m_arready, m_rlast, m_rvalid;
   logic [N*IW-1:0] m_rid;
   logic [N*DW-1:0] m_rdata;
   logic [N*2-1:0]  m_rresp;
   logic [SW-1:0]   s_arid;
   logic [AW-1:0]   s_araddr;
   logic [3:0]      s_arlen, s_arcache;
   logic [2:0]      s_arsize, s_arprot;
   logic [1:0]      s_arburst, s_arlock;
   logic            s_arvalid, s_rready, dbg_state;
   logic            s_arready = 1'b0;
   logic [SW-1:0]   s_rid = '0;
   logic [DW-1:0]   s_rdata = '0;
   logic [1:0]      s_rresp = '0;
   logic            s_rlast = 1'b0, s_rvalid = 1'b0;

   logic [N3-1:0]    m_rready3 = '0;
   logic [SW3-1:0]   s_rid3 = '0;
   logic [N3-1:0]    m_arready3, m_rlast3, m_rvalid3;
   logic [N3*IW-1:0] m_rid3;
   logic [N3*DW-1:0] m_rdata3;
   logic [N3*2-1:0]  m_rresp3;
   logic [SW3-1:0]   s_arid3;
   logic [AW-1:0]    s_araddr3;
   logic [3:0]       s_arlen3, s_arcache3;
   logic [2:0]       s_arsize3, s_arprot3;
   logic [1:0]       s_arburst3, s_arlock3;
   logic             s_arvalid3, s_rready3, dbg_state3;

   int cmp_cnt = 0;
   int err_cnt = 0;
   logic [DW-1:0] exp_q[$];

   // Clock and reset block
   always #5 aclk = ~aclk;

   amba3_axi_rd_arbiter #(.NUM_MASTERS(N), .AXID_SIZE(IW), .ADDR_SIZE(AW), .DATA_SIZE(DW),
                          .MAX_OUTSTANDING(2)) u_dut (
      .aclk(aclk), .areset(areset),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .dbg_state(dbg_state));

   amba3_axi_rd_arbiter #(.NUM_MASTERS(N3), .AXID_SIZE(IW), .ADDR_SIZE(AW), .DATA_SIZE(DW),
                          .MAX_OUTSTANDING(2)) u_dut3 (
      .aclk(aclk), .areset(areset),
      .m_arid('0), .m_araddr('0), .m_arlen('0), .m_arsize('0),
      .m_arburst('0), .m_arlock('0), .m_arcache('0), .m_arprot('0),
      .m_arvalid('0), .m_arready(m_arready3),
      .m_rid(m_rid3), .m_rdata(m_rdata3), .m_rresp(m_rresp3), .m_rlast(m_rlast3),
      .m_rvalid(m_rvalid3), .m_rready(m_rready3),
      .s_arid(s_arid3), .s_araddr(s_araddr3), .s_arlen(s_arlen3), .s_arsize(s_arsize3),
      .s_arburst(s_arburst3), .s_arlock(s_arlock3), .s_arcache(s_arcache3), .s_arprot(s_arprot3),
      .s_arvalid(s_arvalid3), .s_arready(1'b0),
      .s_rid(s_rid3), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready3), .dbg_state(dbg_state3));

   // Driver tasks
   task automatic do_reset();
      areset = 1'b1; m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b0;
      m_rready = '0; m_rready3 = '0;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
   endtask

   task automatic set_master(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [3:0] len, input logic [2:0] prot);
      m_arid[i*IW +: IW] = id;
      m_araddr[i*AW +: AW] = addr;
      m_arlen[i*4 +: 4] = len;
      m_arprot[i*3 +: 3] = prot;
   endtask

   task automatic test_reset();
      areset = 1'b1; m_arvalid = 2'b11; s_rvalid = 1'b1; s_rid = '0; m_rready = 2'b11;
      s_rid3 = '0; m_rready3 = 3'b111;
      @(posedge aclk); #1;
      @(negedge aclk);
      cmp_cnt++; if (m_arready !== 2'b00) begin err_cnt++; $display("FAIL reset_arready: got %b want 00", m_arready); end
      cmp_cnt++; if (m_rvalid !== 2'b00 || m_rvalid3 !== 3'b000) begin err_cnt++; $display("FAIL reset_rvalid: got %b/%b want 0", m_rvalid, m_rvalid3); end
      cmp_cnt++; if (s_rready !== 1'b0 || s_rready3 !== 1'b0) begin err_cnt++; $display("FAIL reset_rready: got %b/%b want 0", s_rready, s_rready3); end
      cmp_cnt++; if ({s_arvalid, dbg_state} !== 2'b00) begin err_cnt++; $display("FAIL reset_state: got %b want 00", {s_arvalid, dbg_state}); end
      cmp_cnt++; if ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot} !== '0) begin
         err_cnt++; $display("FAIL reset_fields: got id %h addr %h want 0", s_arid, s_araddr); end
      @(posedge aclk); #1;
      areset = 1'b0; m_arvalid = '0; s_rvalid = 1'b0; m_rready = '0; m_rready3 = '0;
   endtask

   task automatic test_alternate();
      logic [N-1:0]  e_rdy [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
      logic          e_v   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [SW-1:0] e_id  [5] = '{5'h00, 5'h0A, 5'h00, 5'h13, 5'h00};
      logic [AW-1:0] e_ad  [5] = '{32'h0, 32'h100, 32'h0, 32'h200, 32'h0};
      do_reset();
      set_master(0, 4'hA, 32'h100, 4'd1, 3'd0);
      set_master(1, 4'h3, 32'h200, 4'd2, 3'd1);
      m_arvalid = 2'b11; s_arready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk);
         cmp_cnt++; if (m_arready !== e_rdy[c]) begin err_cnt++; $display("FAIL alt_arready[%0d]: got %b want %b", c, m_arready, e_rdy[c]); end
         cmp_cnt++; if (s_arvalid !== e_v[c]) begin err_cnt++; $display("FAIL alt_arvalid[%0d]: got %b want %b", c, s_arvalid, e_v[c]); end
         if (e_v[c]) begin
            cmp_cnt++; if (s_arid !== e_id[c] || s_araddr !== e_ad[c]) begin err_cnt++;
               $display("FAIL alt_fields[%0d]: got %h/%h want %h/%h", c, s_arid, s_araddr, e_id[c], e_ad[c]); end
         end
         @(posedge aclk); #1;
      end
      m_arvalid = '0; s_arready = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      set_master(1, 4'h5, 32'h1000, 4'd3, 3'd2);
      set_master(0, 4'h9, 32'h2000, 4'd1, 3'd0);
      m_arvalid = 2'b10; s_arready = 1'b0;
      @(negedge aclk);
      cmp_cnt++; if (m_arready !== 2'b10) begin err_cnt++; $display("FAIL stall_grant: got %b want 10", m_arready); end
      @(posedge aclk); #1;
      m_arvalid = 2'b01;
      for (int s = 0; s < 4; s++) begin
         @(negedge aclk);
         cmp_cnt++; if (s_arvalid !== 1'b1 || s_arid !== 5'h15 || s_araddr !== 32'h1000 || s_arlen !== 4'd3 || s_arprot !== 3'd2) begin
            err_cnt++; $display("FAIL stall_hold[%0d]: got v%b id %h addr %h len %0d prot %0d want v1 id 15 addr 1000 len 3 prot 2",
                                s, s_arvalid, s_arid, s_araddr, s_arlen, s_arprot); end
         cmp_cnt++; if (m_arready !== 2'b00) begin err_cnt++; $display("FAIL stall_noready[%0d]: got %b want 00", s, m_arready); end
         @(posedge aclk); #1;
         s_arready = (s == 2);
      end
      @(negedge aclk);
      cmp_cnt++; if (s_arvalid !== 1'b0) begin err_cnt++; $display("FAIL stall_release: got %b want 0", s_arvalid); end
      cmp_cnt++; if (m_arready !== 2'b01) begin err_cnt++; $display("FAIL stall_next: got %b want 01", m_arready); end
      @(posedge aclk); #1;
      m_arvalid = '0;
   endtask

   task automatic test_r_burst();
      logic [DW-1:0] data [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
      int b = 0; int guard = 0; bit stalled = 0; logic rdy1;
      s_rid = 5'h15;
      for (int i = 0; i < 4; i++) exp_q.push_back(data[i]);
      while (b < 4 && guard < 20) begin
         guard++;
         rdy1 = !(b == 2 && !stalled);
         s_rdata = data[b]; s_rlast = (b == 3); s_rvalid = 1'b1; s_rresp = 2'(b);
         m_rready = {rdy1, 1'b1};
         @(negedge aclk);
         cmp_cnt++; if (m_rvalid !== 2'b10) begin err_cnt++; $display("FAIL rb_rvalid[%0d]: got %b want 10", b, m_rvalid); end
         cmp_cnt++; if (m_rid[IW +: IW] !== 4'h5 || m_rdata[DW +: DW] !== exp_q[0] || m_rlast[1] !== (b == 3)) begin
            err_cnt++; $display("FAIL rb_payload[%0d]: got id %h data %h last %b want id 5 data %h last %b",
                                b, m_rid[IW +: IW], m_rdata[DW +: DW], m_rlast[1], exp_q[0], (b == 3)); end
         cmp_cnt++; if (s_rready !== rdy1) begin err_cnt++; $display("FAIL rb_rready[%0d]: got %b want %b", b, s_rready, rdy1); end
         @(posedge aclk); #1;
         if (rdy1) begin void'(exp_q.pop_front()); b++; end
         else stalled = 1;
      end
      cmp_cnt++; if (b != 4) begin err_cnt++; $display("FAIL rb_timeout: got %0d beats want 4", b); end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_master(0, 4'h7, 32'hABCD, 4'd5, 3'd3);
      m_arvalid = 2'b01; s_arready = 1'b0;
      @(negedge aclk);
      cmp_cnt++; if (m_arready !== 2'b01) begin err_cnt++; $display("FAIL rm_grant: got %b want 01", m_arready); end
      @(posedge aclk); #1;
      m_arvalid = 2'b00;
      @(negedge aclk);
      cmp_cnt++; if (s_arvalid !== 1'b1) begin err_cnt++; $display("FAIL rm_issue: got %b want 1", s_arvalid); end
      @(posedge aclk); #1;
      areset = 1'b1; m_arvalid = 2'b11;
      @(negedge aclk);
      cmp_cnt++; if (m_arready !== 2'b00) begin err_cnt++; $display("FAIL rm_in_reset: got %b want 00", m_arready); end
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      cmp_cnt++; if (s_arvalid !== 1'b0 || dbg_state !== 1'b0 || s_arid !== '0 || s_araddr !== '0 || s_arlen !== '0) begin
         err_cnt++; $display("FAIL rm_cleared: got v%b st%b id %h addr %h len %0d want all 0", s_arvalid, dbg_state, s_arid, s_araddr, s_arlen); end
      cmp_cnt++; if (m_arready !== 2'b01) begin err_cnt++; $display("FAIL rm_first: got %b want 01", m_arready); end
      @(posedge aclk); #1;
      m_arvalid = '0;
   endtask

   // Reference model: one request may sit in the slave register at a time; while
   // the register is free, the next pending master after the last grant (modulo N) wins.
   task automatic test_random_ar();
      logic [N-1:0] pend = '0;
      logic [IW-1:0] pid [N]; logic [AW-1:0] paddr [N]; logic [3:0] plen [N]; logic [2:0] pprot [N];
      int waits [N]; int last; int win; bit busy;
      logic [N-1:0] e_rdy; logic [SW-1:0] e_id; logic [AW-1:0] e_addr; logic [3:0] e_len; logic [2:0] e_prot;
      do_reset();
      last = N - 1; busy = 0; e_id = '0; e_addr = '0; e_len = '0; e_prot = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1; pid[i] = IW'($urandom); paddr[i] = $urandom;
               plen[i] = 4'($urandom_range(0, 15)); pprot[i] = 3'($urandom); waits[i] = 0;
               set_master(i, pid[i], paddr[i], plen[i], pprot[i]);
            end
         end
         m_arvalid = pend;
         s_arready = 1'($urandom_range(0, 1));
         @(negedge aclk);
         win = -1;
         if (!busy)
            for (int k = 1; k <= N; k++)
               if (win < 0 && pend[(last + k) % N]) win = (last + k) % N;
         e_rdy = (win >= 0) ? N'(1 << win) : '0;
         cmp_cnt++; if (m_arready !== e_rdy) begin err_cnt++; $display("FAIL rnd_arready[%0d]: got %b want %b", cyc, m_arready, e_rdy); end
         cmp_cnt++; if (s_arvalid !== busy) begin err_cnt++; $display("FAIL rnd_arvalid[%0d]: got %b want %b", cyc, s_arvalid, busy); end
         if (busy) begin
            cmp_cnt++; if (s_arid !== e_id || s_araddr !== e_addr || s_arlen !== e_len || s_arprot !== e_prot) begin
               err_cnt++; $display("FAIL rnd_fields[%0d]: got %h/%h/%0d/%0d want %h/%h/%0d/%0d",
                                   cyc, s_arid, s_araddr, s_arlen, s_arprot, e_id, e_addr, e_len, e_prot); end
         end
         @(posedge aclk); #1;
         if (busy) begin
            if (s_arready) busy = 0;
         end else if (win >= 0) begin
            busy = 1; last = win; pend[win] = 1'b0;
            e_id = {XW'(win), pid[win]}; e_addr = paddr[win]; e_len = plen[win]; e_prot = pprot[win];
            for (int j = 0; j < N; j++) begin
               if (pend[j]) begin
                  waits[j]++;
                  cmp_cnt++; if (waits[j] > N - 1) begin err_cnt++; $display("FAIL rnd_fair[%0d]: got %0d waits want <= %0d", j, waits[j], N - 1); end
               end
            end
         end
      end
      m_arvalid = '0; s_arready = 1'b0;
   endtask

   // R routing model: prefix selects a master; an unmapped prefix is accepted and dropped.
   task automatic test_r_random();
      int ix, ix3;
      logic [N-1:0] e_mv; logic e_sr; logic [N3-1:0] e_mv3; logic e_sr3;
      for (int it = 0; it < 150; it++) begin
         s_rid = SW'($urandom); s_rid3 = SW3'($urandom); s_rdata = $urandom; s_rresp = 2'($urandom);
         s_rlast = 1'($urandom); s_rvalid = 1'($urandom); m_rready = N'($urandom); m_rready3 = N3'($urandom);
         @(negedge aclk);
         ix = int'(s_rid) / (1 << IW);
         ix3 = int'(s_rid3) / (1 << IW);
         e_mv = '0; e_sr = m_rready[ix];
         if (s_rvalid) e_mv = N'(1 << ix);
         e_mv3 = '0; e_sr3 = 1'b1;
         if (ix3 < N3) begin
            e_sr3 = m_rready3[ix3];
            if (s_rvalid) e_mv3 = N3'(1 << ix3);
         end
         cmp_cnt++; if (m_rvalid !== e_mv || s_rready !== e_sr) begin err_cnt++;
            $display("FAIL rr_route[%0d]: got %b/%b want %b/%b", it, m_rvalid, s_rready, e_mv, e_sr); end
         cmp_cnt++; if (m_rvalid3 !== e_mv3 || s_rready3 !== e_sr3) begin err_cnt++;
            $display("FAIL rr_route3[%0d]: idx %0d got %b/%b want %b/%b", it, ix3, m_rvalid3, s_rready3, e_mv3, e_sr3); end
         cmp_cnt++; if (m_rid !== {N{s_rid[IW-1:0]}} || m_rdata !== {N{s_rdata}} || m_rresp !== {N{s_rresp}} || m_rlast !== {N{s_rlast}}) begin
            err_cnt++; $display("FAIL rr_payload[%0d]: got id %h data %h want id %h data %h", it, m_rid, m_rdata, {N{s_rid[IW-1:0]}}, {N{s_rdata}}); end
         cmp_cnt++; if (m_rid3 !== {N3{s_rid3[IW-1:0]}}) begin err_cnt++;
            $display("FAIL rr_rid3[%0d]: got %h want %h", it, m_rid3, {N3{s_rid3[IW-1:0]}}); end
         @(posedge aclk); #1;
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0; m_rready3 = '0;
   endtask

`ifdef AMBA3_AXI_RD_ARB_OUTSTANDING_EN
   // With a limit of 2, master 0 gets two grants, is then skipped, and recovers after one rlast.
   task automatic test_outstanding();
      logic [N-1:0] arv  [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
      bit           rbt  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      logic [N-1:0] e_rdy[9] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
      do_reset();
      s_arready = 1'b1; m_rready = 2'b01; s_rid = {1'b0, 4'h2};
      for (int c = 0; c < 9; c++) begin
         m_arvalid = arv[c]; s_rvalid = rbt[c]; s_rlast = rbt[c];
         @(negedge aclk);
         cmp_cnt++; if (m_arready !== e_rdy[c]) begin err_cnt++; $display("FAIL os_arready[%0d]: got %b want %b", c, m_arready, e_rdy[c]); end
         @(posedge aclk); #1;
      end
      m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
   endtask
`endif

   // Sequencer and final report
   initial begin
      test_reset();
      test_alternate();
      test_stall();
      test_r_burst();
      test_reset_mid();
      test_random_ar();
      test_r_random();
`ifdef AMBA3_AXI_RD_ARB_OUTSTANDING_EN
      test_outstanding();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
